// File: rtl/serial_lut_bank.sv
// serial_lut_bank: double-buffered serially loaded LUT with per-channel registered lookup.
// A frame commits to the active table only when exactly one full table's worth of bits arrived.
module serial_lut_bank #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int CHANNELS  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          d,
    input  logic                          cs_n,
    input  logic [CHANNELS*IN_WIDTH-1:0]  sel,
    output logic [CHANNELS*OUT_WIDTH-1:0] out,
    output logic                          sdo,
    output logic                          loading,
    output logic                          valid,
    output logic                          done,
    output logic                          frame_err
);
    localparam int DEPTH = 2**IN_WIDTH;
    localparam int TB    = DEPTH*OUT_WIDTH;
    localparam int CW    = $clog2(TB+2);
    localparam logic [CW-1:0] CNT_FULL = CW'(TB);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TB+1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                        state_q, state_d;
    logic [TB-1:0]                 shadow_q, shadow_d, active_q, active_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [CHANNELS*OUT_WIDTH-1:0] out_q, out_d;
    logic                          valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic [OUT_WIDTH-1:0]          entry [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign entry[i] = active_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (!cs_n) begin
            state_d  = LOAD;
            shadow_d = {shadow_q[TB-2:0], d};
            cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end else if (state_q == LOAD) begin
            // deselect edge: commit only an exact-length frame
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = (cnt_q == CNT_FULL);
            err_d    = !done_d;
            active_d = done_d ? shadow_q : active_q;
            valid_d  = valid_q | done_d;
        end
    end

    always_comb begin
        out_d = '0;
        for (int c = 0; c < CHANNELS; c++)
            out_d[c*OUT_WIDTH +: OUT_WIDTH] = entry[sel[c*IN_WIDTH +: IN_WIDTH]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out       = out_q;
    assign sdo       = shadow_q[TB-1];
    assign loading   = (state_q == LOAD);
    assign valid     = valid_q;
    assign done      = done_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_serial_lut_bank.sv
// tb_serial_lut_bank: directed vectors for load, frame errors, glitch-free reload, reset and daisy-chaining.
module tb_serial_lut_bank;
    logic       clk, rst, d, cs_n;
    logic [7:0] sel, out_w;
    logic       sdo, loading, valid, done, frame_err;

    logic       c_d, c_cs0, c_cs1;
    logic [7:0] c_sel0, c_sel1, c_out0, c_out1;
    logic       sdo0, sdo1, ld0, ld1, v0, v1, dn0, dn1, fe0, fe1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t va [6];
    vec_t vb [4];
    vec_t vc [4];

    localparam logic [63:0] TBL_ID  = 64'hFEDCBA9876543210;
    localparam logic [63:0] TBL_INV = 64'h0123456789ABCDEF;
    localparam logic [63:0] TBL_P   = 64'h0F1E2D3C4B5A6978;

    serial_lut_bank u_dut (
        .clk(clk), .rst(rst), .d(d), .cs_n(cs_n), .sel(sel), .out(out_w),
        .sdo(sdo), .loading(loading), .valid(valid), .done(done), .frame_err(frame_err)
    );

    serial_lut_bank u_t0 (
        .clk(clk), .rst(rst), .d(c_d), .cs_n(c_cs0), .sel(c_sel0), .out(c_out0),
        .sdo(sdo0), .loading(ld0), .valid(v0), .done(dn0), .frame_err(fe0)
    );

    serial_lut_bank u_t1 (
        .clk(clk), .rst(rst), .d(sdo0), .cs_n(c_cs1), .sel(c_sel1), .out(c_out1),
        .sdo(sdo1), .loading(ld1), .valid(v1), .done(dn1), .frame_err(fe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // shift n bits MSB first (zeros past bit 64), then deselect and check the commit outcome
    task automatic send(input logic [63:0] v, input int n, input bit ok, input bit hold, input logic [7:0] eo);
        for (int i = 0; i < n; i++) begin
            d    = (i < 64) ? v[63-i] : 1'b0;
            cs_n = 1'b0;
            step();
            if (i == 0) chk("loading_high", loading, 1);
            if (hold) chk("hold_during_load", out_w, eo);
        end
        cs_n = 1'b1;
        step();
        chk("done_at_commit", done, ok);
        chk("frame_err_at_commit", frame_err, !ok);
        chk("loading_low", loading, 0);
        if (hold) chk("hold_at_commit_edge", out_w, eo);
        step();
        chk("pulse_one_cycle", {done, frame_err}, 0);
    endtask

    task automatic look(input logic [7:0] s, input logic [7:0] e, input string name);
        sel = s;
        step();
        chk(name, out_w, e);
    endtask

    initial begin
        va[0] = '{8'h5A, 8'h5A};
        va[1] = '{8'hF0, 8'hF0};
        va[2] = '{8'h00, 8'h00};
        va[3] = '{8'hFF, 8'hFF};
        va[4] = '{8'h1E, 8'h1E};
        va[5] = '{8'h77, 8'h77};
        vb[0] = '{8'h21, 8'hDE};
        vb[1] = '{8'h00, 8'hFF};
        vb[2] = '{8'hFF, 8'h00};
        vb[3] = '{8'h5A, 8'hA5};
        vc[0] = '{8'h01, 8'h87};
        vc[1] = '{8'hFA, 8'h0D};
        vc[2] = '{8'h23, 8'h96};
        vc[3] = '{8'h4C, 8'hAE};

        rst = 1'b1; d = 1'b0; cs_n = 1'b1; sel = 8'h00;
        c_d = 1'b0; c_cs0 = 1'b1; c_cs1 = 1'b1; c_sel0 = 8'h00; c_sel1 = 8'h00;
        #23;
        chk("reset_out", out_w, 0);
        chk("reset_flags", {sdo, loading, valid, done, frame_err}, 0);
        rst = 1'b0;
        step();

        send(TBL_ID, 64, 1, 0, 8'h00);
        chk("valid_after_commit", valid, 1);
        for (int i = 0; i < 6; i++) look(va[i].sel, va[i].exp, "lookup_id_table");

        send(64'h0, 63, 0, 0, 8'h00);
        chk("valid_sticky_short", valid, 1);
        look(8'h33, 8'h33, "lookup_after_short");

        send(64'hAAAA_5555_0000_FFFF, 65, 0, 0, 8'h00);
        chk("cnt_cleared_after_long", u_dut.cnt_q, 0);
        look(8'hF0, 8'hF0, "lookup_after_long");

        look(8'h21, 8'h21, "prehold");
        send(TBL_INV, 64, 1, 1, 8'h21);
        chk("new_table_at_ec_plus1", out_w, 8'hDE);
        for (int i = 0; i < 4; i++) look(vb[i].sel, vb[i].exp, "lookup_inv_table");

        // asynchronous reset in the middle of a load
        for (int i = 0; i < 10; i++) begin
            d = i[0];
            cs_n = 1'b0;
            step();
        end
        chk("loading_before_reset", {loading, valid}, 2'b11);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_out", out_w, 0);
        chk("async_reset_flags", {loading, valid, done, frame_err, sdo}, 0);
        cs_n = 1'b1;
        step();
        rst = 1'b0;
        sel = 8'hFF;
        step();
        chk("post_reset_quiet", {out_w, valid, done, frame_err}, 0);

        // tile 0 preload alone so its shadow holds P for the chain shift
        for (int i = 0; i < 64; i++) begin
            c_d = TBL_P[63-i];
            c_cs0 = 1'b0;
            step();
        end
        c_cs0 = 1'b1;
        step();
        chk("chain_t0_preload_done", dn0, 1);
        for (int i = 0; i < 128; i++) begin
            c_d   = i[1] ^ i[3];
            c_cs0 = 1'b0;
            c_cs1 = (i < 64) ? 1'b0 : 1'b1;
            step();
            if (i == 64) chk("chain_t1_done", {dn1, fe1}, 2'b10);
        end
        c_cs0 = 1'b1;
        step();
        chk("chain_t0_frame_err", {dn0, fe0}, 2'b01);
        chk("chain_t1_valid", v1, 1);
        for (int i = 0; i < 4; i++) begin
            c_sel0 = vc[i].sel;
            c_sel1 = vc[i].sel;
            step();
            chk("chain_t1_lookup", c_out1, vc[i].exp);
            chk("chain_t0_unchanged", c_out0, vc[i].exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
